// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared constants, state encoding and size helpers for the LSU memory master
// Build option: LSU_MISALIGN_TRAP_EN (used by lsu_mem_master) selects trap vs. silent realignment.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_MERGE,
        S_WR,
        S_RESP
    } state_t;

    typedef enum logic [1:0] {
        SZ_B,
        SZ_H,
        SZ_W
    } size_t;

    // Unsupported encodings (011, 110, 111) fall through to word accesses.
    function automatic size_t f3_size(input logic [2:0] f3);
        case (f3)
            F3_B, F3_BU: return SZ_B;
            F3_H, F3_HU: return SZ_H;
            F3_W:        return SZ_W;
            default:     return SZ_W;
        endcase
    endfunction

    // Clears the low address bits that a naturally aligned access of this size cannot have.
    function automatic logic [1:0] align_lo(input size_t sz, input logic [1:0] lo);
        case (sz)
            SZ_B:    return lo;
            SZ_H:    return {lo[1], 1'b0};
            default: return 2'b00;
        endcase
    endfunction

    function automatic logic misaligned(input size_t sz, input logic [1:0] lo);
        case (sz)
            SZ_B:    return 1'b0;
            SZ_H:    return lo[0];
            default: return lo != 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// rtl/lsu_lane_align.sv - combinational byte/half lane extraction for loads and lane merge for stores
// Ports:
//   funct3   in  3   access type of the captured request
//   addr_lo  in  2   byte offset within the word (already realigned)
//   ld_word  in  32  word read from memory
//   ld_data  out 32  selected lane, sign- or zero-extended
//   old_word in  32  previous memory contents for a sub-word store
//   wdata    in  32  right-aligned store data
//   st_word  out 32  old_word with the addressed lane replaced
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] ld_word,
    output logic [31:0] ld_data,
    input  logic [31:0] old_word,
    input  logic [31:0] wdata,
    output logic [31:0] st_word
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = ld_word[{addr_lo, 3'b000} +: 8];
        half_sel = addr_lo[1] ? ld_word[31:16] : ld_word[15:0];
        ld_data  = ld_word;
        case (funct3)
            F3_B:    ld_data = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   ld_data = {24'h0, byte_sel};
            F3_H:    ld_data = {{16{half_sel[15]}}, half_sel};
            F3_HU:   ld_data = {16'h0, half_sel};
            default: ld_data = ld_word;
        endcase
    end

    always_comb begin
        st_word = old_word;
        case (f3_size(funct3))
            SZ_B: st_word[{addr_lo, 3'b000} +: 8] = wdata[7:0];
            SZ_H: begin
                if (addr_lo[1]) begin
                    st_word[31:16] = wdata[15:0];
                end else begin
                    st_word[15:0] = wdata[15:0];
                end
            end
            default: st_word = wdata;
        endcase
    end

endmodule

// File: rtl/lsu_mem_master.sv
// rtl/lsu_mem_master.sv - load/store initiator with sub-word read-modify-write for a word-organised memory
// Build option: LSU_MISALIGN_TRAP_EN - misaligned half/word accesses respond with resp_err and touch no memory;
//   when undefined the offending low address bits are cleared and the access proceeds.
// Ports:
//   clk, rst                          clock, asynchronous active-low reset
//   req_valid/req_ready               request handshake (ready only while idle)
//   req_we, req_funct3, req_addr, req_wdata  request fields, captured on accept
//   resp_valid, resp_rdata, resp_err  one-cycle registered response
//   mem_addr, mem_wdata, mem_we       word-indexed memory drive
//   mem_rdata                         combinational read data for mem_addr
module lsu_mem_master
    import lsu_pkg::*;
#(
    parameter int MEM_IDX_W = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_we,
    input  logic [2:0]           req_funct3,
    input  logic [31:0]          req_addr,
    input  logic [31:0]          req_wdata,
    output logic                 resp_valid,
    output logic [31:0]          resp_rdata,
    output logic                 resp_err,
    output logic [MEM_IDX_W-1:0] mem_addr,
    output logic [31:0]          mem_wdata,
    output logic                 mem_we,
    input  logic [31:0]          mem_rdata
);

    localparam int AW = MEM_IDX_W + 2;

    state_t        state_q, state_d;
    logic          we_q, we_d;
    logic [2:0]    funct3_q, funct3_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [31:0]   data_q, data_d;
    logic          resp_valid_q, resp_valid_d;
    logic [31:0]   resp_rdata_q, resp_rdata_d;
    logic          resp_err_q, resp_err_d;

    logic [31:0]   ld_data;
    logic [31:0]   st_word;
    size_t         req_size;

    // Address bits above the memory index wrap around.
    logic          unused_addr_hi;
    assign unused_addr_hi = ^req_addr[31:AW];

    lsu_lane_align u_lane_align (
        .funct3   (funct3_q),
        .addr_lo  (addr_q[1:0]),
        .ld_word  (mem_rdata),
        .ld_data  (ld_data),
        .old_word (data_q),
        .wdata    (wdata_q),
        .st_word  (st_word)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            we_q         <= 1'b0;
            funct3_q     <= 3'b000;
            addr_q       <= '0;
            wdata_q      <= 32'h0;
            data_q       <= 32'h0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'h0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            we_q         <= we_d;
            funct3_q     <= funct3_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            data_q       <= data_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        we_d         = we_q;
        funct3_d     = funct3_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        data_d       = data_q;
        resp_valid_d = 1'b0;
        resp_rdata_d = 32'h0;
        resp_err_d   = 1'b0;
        req_size     = f3_size(req_funct3);

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    we_d     = req_we;
                    funct3_d = req_funct3;
                    addr_d   = {req_addr[AW-1:2], align_lo(req_size, req_addr[1:0])};
                    wdata_d  = req_wdata;
                    // A word store goes straight to WR, so its write word is loaded here.
                    data_d   = req_wdata;
`ifdef LSU_MISALIGN_TRAP_EN
                    if (misaligned(req_size, req_addr[1:0])) begin
                        state_d      = S_RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                    end else
`endif
                    if (req_we && (req_size == SZ_W)) begin
                        state_d = S_WR;
                    end else begin
                        state_d = S_RD;
                    end
                end
            end
            S_RD: begin
                data_d = mem_rdata;
                if (we_q) begin
                    state_d = S_MERGE;
                end else begin
                    state_d      = S_RESP;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = ld_data;
                end
            end
            S_MERGE: begin
                data_d  = st_word;
                state_d = S_WR;
            end
            S_WR: begin
                state_d      = S_RESP;
                resp_valid_d = 1'b1;
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign req_ready  = (state_q == S_IDLE);
    // Decoded straight from the state flop so an asynchronous reset removes the write at once.
    assign mem_we     = (state_q == S_WR);
    assign mem_addr   = addr_q[AW-1:2];
    assign mem_wdata  = data_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;

endmodule
